// File: rtl/switch_alloc.sv
// Wormhole switch allocator: per-output round-robin grant with head-to-tail locking and downstream credit tracking.
// Latency 0 (grants are combinational from inputs and state); an output stalls while its credit count is zero or its owner is idle.
module switch_alloc #(
  parameter int NPORT   = 5,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORT-1:0]       req_valid,
  input  logic [NPORT*NPORT-1:0] req_port,
  input  logic [NPORT-1:0]       req_tail,
  input  logic [NPORT-1:0]       credit_in,
  output logic [NPORT-1:0]       rd_en,
  output logic [NPORT*NPORT-1:0] sel,
  output logic [NPORT-1:0]       out_valid,
  output logic [NPORT-1:0]       busy,
  output logic                   credit_err
);

  localparam int PW = $clog2(NPORT);

  typedef logic [NPORT-1:0] vec_t;

  function automatic vec_t lowest_one(input vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

  // (p + k) mod NPORT for p < NPORT and k < NPORT
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NPORT) s = s - NPORT;
    return PW'(s);
  endfunction

  logic [NPORT-1:0] lock;
  logic [PW-1:0]    owner [NPORT];
  logic [PW-1:0]    ptr   [NPORT];
  logic [CW-1:0]    cred  [NPORT];
  logic             err_q;

  vec_t             want  [NPORT];
  vec_t             elig  [NPORT];
  vec_t             pick  [NPORT];
  vec_t             grant [NPORT];
  logic [PW-1:0]    win   [NPORT];
  logic [NPORT-1:0] win_tail;

  // want[i] is the single output input i asks for; elig[o] is the transposed view
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      want[i] = req_valid[i] ? lowest_one(req_port[i*NPORT +: NPORT]) : '0;
    end
    for (int o = 0; o < NPORT; o++) begin
      elig[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        elig[o][i] = want[i][o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      pick[o]     = '0;
      grant[o]    = '0;
      win[o]      = '0;
      win_tail[o] = 1'b0;
      // a locked output listens only to its owner, even if others hold head flits
      if (lock[o]) begin
        pick[o][owner[o]] = elig[o][owner[o]];
      end else begin
        for (int k = 0; k < NPORT; k++) begin
          if (pick[o] == '0 && elig[o][next_idx(ptr[o], k)]) begin
            pick[o][next_idx(ptr[o], k)] = 1'b1;
          end
        end
      end
      if (rst_n && cred[o] != '0) begin
        grant[o] = pick[o];
      end
      for (int i = 0; i < NPORT; i++) begin
        if (grant[o][i]) begin
          win[o]      = PW'(i);
          win_tail[o] = req_tail[i];
        end
      end
    end
  end

  always_comb begin
    rd_en     = '0;
    sel       = '0;
    out_valid = '0;
    for (int o = 0; o < NPORT; o++) begin
      sel[o*NPORT +: NPORT] = grant[o];
      out_valid[o]          = |grant[o];
      rd_en                 = rd_en | grant[o];
    end
  end

  assign busy       = rst_n ? lock : '0;
  assign credit_err = rst_n & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock  <= '0;
      err_q <= 1'b0;
      for (int o = 0; o < NPORT; o++) begin
        owner[o] <= '0;
        ptr[o]   <= '0;
        cred[o]  <= CW'(CREDITS);
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (|grant[o]) begin
          // a returning credit cancels the one spent by this grant
          if (!credit_in[o]) cred[o] <= cred[o] - 1'b1;
          if (win_tail[o]) begin
            lock[o] <= 1'b0;
            ptr[o]  <= next_idx(win[o], 1);
          end else begin
            lock[o]  <= 1'b1;
            owner[o] <= win[o];
          end
        end else if (credit_in[o]) begin
          if (cred[o] == CW'(CREDITS)) err_q <= 1'b1;
          else                         cred[o] <= cred[o] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_alloc.sv
// Bench for switch_alloc: directed scenarios plus random traffic, all compared against a
// port-level reference model of the allocation rules.
module tb_switch_alloc;

  localparam int N  = 5;
  localparam int CR = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  req_valid;
  logic [24:0] req_port;
  logic [4:0]  req_tail;
  logic [4:0]  credit_in;
  logic [4:0]  rd_en;
  logic [24:0] sel;
  logic [4:0]  out_valid;
  logic [4:0]  busy;
  logic        credit_err;
  logic [40:0] obs;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit [4:0] m_lock;
  int       m_owner [N];
  int       m_ptr   [N];
  int       m_cred  [N];
  bit       m_err;
  int       exp_win [N];

  switch_alloc #(.NPORT(5), .CREDITS(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_port(req_port),
    .req_tail(req_tail), .credit_in(credit_in), .rd_en(rd_en), .sel(sel),
    .out_valid(out_valid), .busy(busy), .credit_err(credit_err)
  );

  assign obs = {rd_en, sel, out_valid, busy, credit_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_lock = '0;
    m_err  = 1'b0;
    for (int o = 0; o < N; o++) begin
      m_owner[o] = 0;
      m_ptr[o]   = 0;
      m_cred[o]  = CR;
    end
  endtask

  // Which input wins each output right now (-1 = none).
  task automatic model_eval();
    int tgt [N];
    for (int i = 0; i < N; i++) begin
      tgt[i] = -1;
      if (req_valid[i]) begin
        for (int b = N - 1; b >= 0; b--) if (req_port[i*N + b]) tgt[i] = b;
      end
    end
    for (int o = 0; o < N; o++) begin
      int cand;
      cand = -1;
      if (m_lock[o]) begin
        if (tgt[m_owner[o]] == o) cand = m_owner[o];
      end else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr[o] + k) % N;
          if (cand < 0 && tgt[i] == o) cand = i;
        end
      end
      exp_win[o] = (cand >= 0 && m_cred[o] > 0 && rst_n) ? cand : -1;
    end
  endtask

  task automatic model_edge();
    if (rst_n) begin
      for (int o = 0; o < N; o++) begin
        if (exp_win[o] >= 0) begin
          if (!credit_in[o]) m_cred[o]--;
          if (req_tail[exp_win[o]]) begin
            m_lock[o] = 1'b0;
            m_ptr[o]  = (exp_win[o] + 1) % N;
          end else begin
            m_lock[o]  = 1'b1;
            m_owner[o] = exp_win[o];
          end
        end else if (credit_in[o]) begin
          if (m_cred[o] == CR) m_err = 1'b1;
          else                 m_cred[o]++;
        end
      end
    end
  endtask

  function automatic logic [40:0] exp_vec();
    logic [4:0]  r;
    logic [4:0]  ov;
    logic [24:0] s;
    r = '0; ov = '0; s = '0;
    for (int o = 0; o < N; o++) begin
      if (exp_win[o] >= 0) begin
        r[exp_win[o]]       = 1'b1;
        s[o*N + exp_win[o]] = 1'b1;
        ov[o]               = 1'b1;
      end
    end
    return {r, s, ov, m_lock, m_err};
  endfunction

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_port  = '0;
    req_tail  = '0;
    credit_in = '0;
  endtask

  task automatic set_req(input int i, input int o, input logic tail);
    logic [4:0] one;
    one                = 5'b00001;
    req_valid[i]       = 1'b1;
    req_port[i*N +: N] = one << o;
    req_tail[i]        = tail;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    model_reset();
    req_valid = 5'h1F;
    req_tail  = '0;
    credit_in = '0;
    for (int i = 0; i < N; i++) req_port[i*N +: N] = 5'b00001;
    @(posedge clk);
    #1;
    settle();
    total++; if (rd_en !== 5'h00) begin bad++; $display("FAIL reset_rd_en got=%h exp=00", rd_en); end
    total++; if (sel !== 25'h0) begin bad++; $display("FAIL reset_sel got=%h exp=0", sel); end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec()); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    total++; if (sel[4:0] !== 5'b00001 || rd_en !== 5'b00001) begin
      bad++; $display("FAIL reset_first_grant sel0=%b rd_en=%b exp=00001", sel[4:0], rd_en);
    end
    total++; if (busy !== 5'h00) begin bad++; $display("FAIL reset_busy got=%b exp=00000", busy); end
    tick();
    settle();
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL reset_lock_after_head got=%b exp=1", busy[0]); end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_stream got=%h exp=%h", obs, exp_vec()); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] seq [4];
    seq[0] = 5'b00001; seq[1] = 5'b00100; seq[2] = 5'b10000; seq[3] = 5'b00001;
    apply_reset();
    set_req(0, 1, 1'b1);
    set_req(2, 1, 1'b1);
    set_req(4, 1, 1'b1);
    credit_in = 5'b00010;
    for (int c = 0; c < 4; c++) begin
      settle();
      total++; if (sel[9:5] !== seq[c]) begin bad++; $display("FAIL rr_seq cyc=%0d got=%b exp=%b", c, sel[9:5], seq[c]); end
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, obs, exp_vec()); end
      tick();
    end
    credit_in = '0;
  endtask

  task automatic test_wormhole();
    apply_reset();
    credit_in = 5'b01000;
    set_req(0, 3, 1'b1);
    settle();
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL worm_prime got=%h exp=%h", obs, exp_vec()); end
    tick();
    set_req(1, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req_tail[1] = 1'b1;
      if (k == 3) req_valid[1] = 1'b0;
      settle();
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL worm_model k=%0d got=%h exp=%h", k, obs, exp_vec()); end
      if (k < 3) begin
        total++; if (sel[19:15] !== 5'b00010) begin bad++; $display("FAIL worm_owner k=%0d got=%b exp=00010", k, sel[19:15]); end
        if (k > 0) begin
          total++; if (busy[3] !== 1'b1) begin bad++; $display("FAIL worm_busy k=%0d got=%b exp=1", k, busy[3]); end
        end
      end else begin
        total++; if (sel[19:15] !== 5'b00001 || busy[3] !== 1'b0) begin
          bad++; $display("FAIL worm_release sel=%b busy=%b exp=00001/0", sel[19:15], busy[3]);
        end
      end
      tick();
    end
    credit_in = '0;
  endtask

  task automatic test_credit_stall();
    logic [11:0] cr_pat;
    logic [11:0] ov_pat;
    cr_pat = 12'h320;
    ov_pat = 12'h64F;
    apply_reset();
    set_req(0, 2, 1'b0);
    for (int k = 0; k < 12; k++) begin
      credit_in = {2'b00, cr_pat[k], 2'b00};
      settle();
      total++; if (out_valid[2] !== ov_pat[k]) begin bad++; $display("FAIL stall_ov k=%0d got=%b exp=%b", k, out_valid[2], ov_pat[k]); end
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL stall_model k=%0d got=%h exp=%h", k, obs, exp_vec()); end
      tick();
    end
    credit_in = '0;
  endtask

  task automatic test_parallel();
    logic [4:0] one;
    logic [4:0] e;
    one = 5'b00001;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, (i + 1) % N, 1'b1);
    settle();
    total++; if (rd_en !== 5'h1F) begin bad++; $display("FAIL par_rd_en got=%b exp=11111", rd_en); end
    for (int o = 0; o < N; o++) begin
      e = one << ((o + N - 1) % N);
      total++; if (sel[o*N +: N] !== e) begin bad++; $display("FAIL par_sel o=%0d got=%b exp=%b", o, sel[o*N +: N], e); end
    end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL par_model got=%h exp=%h", obs, exp_vec()); end
    tick();
  endtask

  task automatic test_reset_mid_and_overflow();
    logic [4:0] e;
    apply_reset();
    set_req(2, 4, 1'b1);
    settle();
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL mid_prime got=%h exp=%h", obs, exp_vec()); end
    tick();
    req_tail[2] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      total++; if (sel[24:20] !== 5'b00100) begin bad++; $display("FAIL mid_flit k=%0d got=%b exp=00100", k, sel[24:20]); end
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    settle();
    total++; if (busy !== 5'h00 || rd_en !== 5'h00) begin bad++; $display("FAIL mid_reset busy=%b rd_en=%b exp=0/0", busy, rd_en); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    set_req(0, 4, 1'b0);
    set_req(3, 4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      e = (k < 4) ? 5'b00001 : 5'b00000;
      settle();
      total++; if (sel[24:20] !== e) begin bad++; $display("FAIL mid_after k=%0d got=%b exp=%b", k, sel[24:20], e); end
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL mid_model k=%0d got=%h exp=%h", k, obs, exp_vec()); end
      tick();
    end
    req_valid = '0;
    credit_in = 5'b00001;
    settle();
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b exp=0", credit_err); end
    tick();
    credit_in = '0;
    for (int k = 0; k < 3; k++) begin
      settle();
      total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky k=%0d got=%b exp=1", k, credit_err); end
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", credit_err); end
    tick();
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_tail[i]  = ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 7);
        if (r < 5)       req_port[i*N +: N] = 5'(1 << r);
        else if (r == 5) req_port[i*N +: N] = 5'b00000;
        else             req_port[i*N +: N] = 5'($urandom_range(0, 31));
      end
      for (int o = 0; o < N; o++) begin
        if (m_cred[o] < CR) credit_in[o] = ($urandom_range(0, 1) == 1);
        else                credit_in[o] = ($urandom_range(0, 49) == 0);
      end
      settle();
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rand cyc=%0d got=%h exp=%h", c, obs, exp_vec()); end
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_parallel();
    test_reset_mid_and_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_alloc.md
# switch_alloc

Credit-aware wormhole switch allocator for the 5-port mesh router. Sits between the per-input route-compute outputs and the crossbar: arbitrates each output port round-robin among requesting inputs, and locks an output to one input from head flit to tail flit. Tracks downstream buffer credits per output. Drives the input-FIFO pop enables and the per-output one-hot crossbar selects.

## Interface
- NPORT, 5, number of router ports (0=local, 1..4=mesh directions); only 5 is supported
- CREDITS, 4, downstream buffer depth per output; credit counter reset value and ceiling
- CW, 3, credit counter width; must hold CREDITS

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  5  bit i: input FIFO i has a flit at its head
- req_port  in  25  bits [5i+4:5i]: one-hot output requested by input i (route-compute e1..e5)
- req_tail  in  5  bit i: head flit of input i is the last flit of its packet (single-flit packet = tail)
- credit_in  in  5  bit o: one-cycle pulse, downstream of output o freed one slot
- rd_en  out  5  bit i: pop input FIFO i this cycle
- sel  out  25  bits [5o+4:5o]: one-hot input driving output o, 0 = idle (crossbar sel format)
- out_valid  out  5  bit o: output o carries a flit this cycle
- busy  out  5  bit o: output o locked to an in-flight packet
- credit_err  out  1  sticky: credit_in received while counter already at CREDITS

## Operation
- Per-output state: lock[o], owner[o] (3b), ptr[o] (3b, range 0..4), cred[o] (CW bits).
- Request decode: eligible(i,o) = req_valid[i] & req_port[5i+o]. A zero req_port = no request. Multi-hot req_port: only the lowest set bit counts.
- Locked output: only owner[o] is considered. It is granted iff eligible(owner,o) and cred[o] > 0. Other inputs wait. This includes head flits.
- Unlocked output: search i = ptr, ptr+1, … mod 5 and pick the first eligible input. It is granted iff cred[o] > 0.
- Each input requests at most one output, so it wins at most one. rd_en[i] = OR over o of grant(i,o).
- sel[o] = one-hot winner; out_valid[o] = |sel[o]; busy[o] = lock[o].
- On grant to input w at output o, the following update at the clock edge:
  - cred[o] decrements by 1. If credit_in[o] is also asserted, the count is unchanged.
  - If req_tail[w] = 0: lock[o] is set and owner[o] = w.
  - If req_tail[w] = 1: lock[o] is cleared and ptr[o] = (w+1) mod 5 (4 wraps to 0).
- Without a grant, credit_in[o] increments cred[o]. At cred = CREDITS the count saturates and credit_err is set.
- ptr does not move while a packet is in flight or on a cycle with no grant.
- Outputs are forced to 0 while rst_n is low.

## Timing
- Grants are combinational from the current inputs and registered state. rd_en, sel and out_valid are valid in the same cycle as the request.
- The FIFO pops and the crossbar registers at the next rising edge. Latency from request to grant is 0 cycles when the output is free and has credit.
- A locked output with an owner holding credit streams one flit per cycle.
- Bubbles: if the owner deasserts req_valid mid-packet, the output idles but stays locked.
- cred = 0 stalls the output. A credit_in pulse in cycle t allows a grant in cycle t+1.
- Reset (asynchronous, any time, including mid-packet):
  - lock = 0, owner = 0, ptr = 0, cred = CREDITS, credit_err = 0.
  - All outputs are 0.
  - The first grant can occur in the first cycle after rst_n rises.

## Test plan
- Reset: hold rst_n=0 with req_valid=5'h1F and every input requesting output 0. Required: rd_en=0, sel=0. After release, input 0 is granted in cycle 1 and busy=0.
- Round-robin: inputs 0, 2 and 4 hold single-flit tail requests to output 1 with credits refilled each cycle. Required: sel[9:5] sequence 00001, 00100, 10000, 00001. ptr wraps 4→0.
- Wormhole lock: input 1 sends a 3-flit packet (tail on flit 3) to output 3 while input 0 also requests output 3. Required:
  - input 1 is granted for 3 consecutive cycles with busy[3]=1;
  - input 0 is granted in cycle 4;
  - busy[3]=0 after the tail.
- Credit stall: with CREDITS=4 and no credit_in, input 0 streams to output 2. Required: 4 grants, then out_valid[2]=0. One credit_in[2] pulse gives exactly one more grant on the next cycle. Grant plus credit_in in the same cycle leaves cred unchanged.
- Parallel: each input i requests output (i+1) mod 5. Required: all five granted in the same cycle, rd_en=5'h1F, and each sel field one-hot.
- Reset mid-packet and overflow:
  - Assert rst_n low after flit 2 of a 3-flit packet. Required: busy=0, ptr=0, cred=4.
  - Pulse credit_in[0] with cred[0]=4. Required: credit_err=1, held until reset.
